// File: rtl/addr_bus_pkg.sv
// Shared types and default widths for the en/wr/addr stimulus bus responder.
package addr_bus_pkg;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {IDLE, FIRST, STREAM} seq_state_t;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
endpackage

// File: rtl/addr_bus_responder_if.sv
// Stimulus bus bundle: initiator drives en/wr/addr/wdata, responder returns data and status.
interface addr_bus_responder_if
    import addr_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic              in_stream;

    modport master (
        output en, wr, addr, wdata,
        input  rdata, rvalid, wr_cnt, rd_cnt, in_stream
    );

    modport slave (
        input  en, wr, addr, wdata,
        output rdata, rvalid, wr_cnt, rd_cnt, in_stream
    );
endinterface

// File: rtl/addr_seq_tracker.sv
// Tracks whether accesses form a sequential run (same direction, address +1 with wrap).
module addr_seq_tracker
    import addr_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    output logic              in_stream
);
    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic              last_wr_q;
    logic [ADDR_W-1:0] next_addr;
    logic              in_stream_q;

    // Kept at ADDR_W bits so that the top address rolls over to 0.
    assign next_addr = last_addr_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = FIRST;
            end
            FIRST, STREAM: begin
                if (!en)
                    state_d = IDLE;
                else if ((addr == next_addr) && (wr == last_wr_q))
                    state_d = STREAM;
                else
                    state_d = FIRST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_addr_q <= '0;
            last_wr_q   <= 1'b0;
            in_stream_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_stream_q <= (state_d == STREAM);
            if (en) begin
                last_addr_q <= addr;
                last_wr_q   <= wr;
            end
        end
    end

    assign in_stream = in_stream_q;
endmodule

// File: rtl/addr_bus_responder.sv
// Bus-target register array with one-cycle read latency, saturating access
// counters and a sequential-run indicator.
module addr_bus_responder
    import addr_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    addr_bus_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic              wr_acc_p0;
    logic              rd_acc_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign wr_acc_p0 = bus.en & bus.wr;
    assign rd_acc_p0 = bus.en & ~bus.wr;

    // p0 -> p1: array access, read data/valid registered, counters updated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            vld_p1 <= rd_acc_p0;
            if (wr_acc_p0) begin
                mem[bus.addr] <= bus.wdata;
                wr_cnt_q      <= sat_inc(wr_cnt_q);
            end
            if (rd_acc_p0) begin
                rdata_p1 <= mem[bus.addr];
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
        end
    end

    addr_seq_tracker #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (bus.en),
        .wr        (bus.wr),
        .addr      (bus.addr),
        .in_stream (bus.in_stream)
    );

    assign bus.rdata  = rdata_p1;
    assign bus.rvalid = vld_p1;
    assign bus.wr_cnt = wr_cnt_q;
    assign bus.rd_cnt = rd_cnt_q;
endmodule

// File: tb/tb_addr_bus_responder.sv
// Directed bench for addr_bus_responder: reset, mixed accesses, wrap streaming,
// read-after-write, direction break and counter saturation.
module tb_addr_bus_responder;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    addr_bus_responder_if bus ();

    addr_bus_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
        bus.en    = e;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 6'd0, 8'h00);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 8'h00);
        cyc();
        cyc();
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_wr_cnt", bus.wr_cnt, 0);
        chk("rst_rd_cnt", bus.rd_cnt, 0);
        chk("rst_in_stream", bus.in_stream, 0);
        rst_n = 1'b1;

        // Build non-zero state, then reset mid-access
        drive(1'b1, 1'b1, 6'd4, 8'h44); cyc();
        drive(1'b1, 1'b1, 6'd5, 8'h55); cyc();
        chk("pre_stream_wr", bus.in_stream, 1);
        drive(1'b1, 1'b0, 6'd4, 8'h00); cyc();
        drive(1'b1, 1'b0, 6'd5, 8'h00); cyc();
        chk("pre_rdata", bus.rdata, 8'h55);
        chk("pre_rvalid", bus.rvalid, 1);
        chk("pre_stream_rd", bus.in_stream, 1);
        chk("pre_cnts", {bus.wr_cnt, bus.rd_cnt}, 16'h0202);
        #5 rst_n = 1'b0;
        #1;
        chk("async_rdata", bus.rdata, 0);
        chk("async_rvalid", bus.rvalid, 0);
        chk("async_cnts", {bus.wr_cnt, bus.rd_cnt}, 0);
        chk("async_in_stream", bus.in_stream, 0);
        drive(1'b0, 1'b0, 6'd0, 8'h00);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 6'd5, 8'h00); cyc();
        chk("post_rst_rdata", bus.rdata, 0);
        chk("post_rst_rvalid", bus.rvalid, 1);
        chk("post_rst_rd_cnt", bus.rd_cnt, 1);
        chk("post_rst_in_stream", bus.in_stream, 0);
        drive(1'b0, 1'b0, 6'd0, 8'h00); cyc();
        chk("post_rst_rvalid_drop", bus.rvalid, 0);

        // Bus sequence: two writes, two reads, idle cycle at 56
        do_reset();
        drive(1'b1, 1'b1, 6'd12, 8'hA5); cyc();
        chk("seq_w12_stream", bus.in_stream, 0);
        chk("seq_w12_rvalid", bus.rvalid, 0);
        drive(1'b1, 1'b1, 6'd14, 8'h3C); cyc();
        chk("seq_w14_stream", bus.in_stream, 0);
        chk("seq_w14_wr_cnt", bus.wr_cnt, 2);
        drive(1'b1, 1'b0, 6'd23, 8'h00); cyc();
        chk("seq_r23_rdata", bus.rdata, 0);
        chk("seq_r23_rvalid", bus.rvalid, 1);
        chk("seq_r23_stream", bus.in_stream, 0);
        drive(1'b1, 1'b0, 6'd48, 8'h00); cyc();
        chk("seq_r48_rdata", bus.rdata, 0);
        chk("seq_r48_rvalid", bus.rvalid, 1);
        chk("seq_r48_stream", bus.in_stream, 0);
        drive(1'b0, 1'b1, 6'd56, 8'hFF); cyc();
        chk("seq_idle_rvalid", bus.rvalid, 0);
        chk("seq_idle_rdata_hold", bus.rdata, 0);
        chk("seq_idle_cnts", {bus.wr_cnt, bus.rd_cnt}, 16'h0202);
        chk("seq_idle_stream", bus.in_stream, 0);
        drive(1'b1, 1'b0, 6'd12, 8'h00); cyc();
        chk("seq_rb12", bus.rdata, 8'hA5);
        drive(1'b1, 1'b0, 6'd14, 8'h00); cyc();
        chk("seq_rb14", bus.rdata, 8'h3C);
        drive(1'b1, 1'b0, 6'd56, 8'h00); cyc();
        chk("seq_rb56_untouched", bus.rdata, 0);

        // Sequential writes across the address wrap
        do_reset();
        drive(1'b1, 1'b1, 6'd62, 8'h62); cyc();
        chk("wrap_62_stream", bus.in_stream, 0);
        drive(1'b1, 1'b1, 6'd63, 8'h63); cyc();
        chk("wrap_63_stream", bus.in_stream, 1);
        drive(1'b1, 1'b1, 6'd0, 8'h70); cyc();
        chk("wrap_0_stream", bus.in_stream, 1);
        drive(1'b1, 1'b1, 6'd1, 8'h71); cyc();
        chk("wrap_1_stream", bus.in_stream, 1);
        chk("wrap_wr_cnt", bus.wr_cnt, 4);
        drive(1'b0, 1'b0, 6'd2, 8'h00); cyc();
        chk("wrap_drop_stream", bus.in_stream, 0);
        drive(1'b1, 1'b0, 6'd0, 8'h00); cyc();
        chk("wrap_rb0", bus.rdata, 8'h70);

        // Read-after-write to the same address
        do_reset();
        drive(1'b1, 1'b1, 6'd9, 8'h77); cyc();
        chk("raw_w_rvalid", bus.rvalid, 0);
        drive(1'b1, 1'b0, 6'd9, 8'h00); cyc();
        chk("raw_rdata", bus.rdata, 8'h77);
        chk("raw_rvalid", bus.rvalid, 1);
        drive(1'b0, 1'b0, 6'd9, 8'h00); cyc();
        chk("raw_rvalid_drop", bus.rvalid, 0);
        chk("raw_rdata_hold", bus.rdata, 8'h77);

        // Direction change breaks the stream
        do_reset();
        drive(1'b1, 1'b1, 6'd20, 8'h20); cyc();
        drive(1'b1, 1'b0, 6'd21, 8'h00); cyc();
        chk("dir_stream", bus.in_stream, 0);
        chk("dir_rd_cnt", bus.rd_cnt, 1);
        chk("dir_wr_cnt", bus.wr_cnt, 1);

        // Write counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, i[5:0], i[7:0]);
            cyc();
            if (i == 253) chk("sat_254", bus.wr_cnt, 254);
            if (i == 254) chk("sat_255", bus.wr_cnt, 255);
            if (i == 255) chk("sat_hold_256", bus.wr_cnt, 255);
        end
        chk("sat_final", bus.wr_cnt, 255);
        chk("sat_rd_cnt", bus.rd_cnt, 0);
        chk("sat_stream", bus.in_stream, 1);
        drive(1'b0, 1'b0, 6'd0, 8'h00); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addr_bus_responder.md
# addr_bus_responder

Target-side responder for the en/wr/addr stimulus bus driven by the team's test tasks. It holds a 64-entry register array, performs writes, and returns read data with one-cycle latency. It counts accepted reads and writes, and tracks whether the initiator is streaming through consecutive addresses. It sits at the far end of the stimulus bus as the device under test and a reusable bus model.

## Interface
- ADDR_W, 6, address width; array depth is 2**ADDR_W
- DATA_W, 8, data width
- CNT_W, 8, width of the access counters
- clk  in  1  single system clock, 25 MHz nominal; all sampling on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  access enable; one access per cycle while high
- wr  in  1  1 = write, 0 = read; ignored when en = 0
- addr  in  ADDR_W  access address
- wdata  in  DATA_W  write data, sampled with en & wr
- rdata  out  DATA_W  read data
- rvalid  out  1  rdata valid pulse
- wr_cnt  out  CNT_W  accepted writes, saturating
- rd_cnt  out  CNT_W  accepted reads, saturating
- in_stream  out  1  high while the current run is sequential

## Operation
- Reset (rst_n low, asynchronous): array cleared to 0, rdata = 0, rvalid = 0, wr_cnt = 0, rd_cnt = 0, in_stream = 0, FSM = IDLE, last_addr = 0, last_wr = 0.
- Write (en=1, wr=1 at edge N): mem[addr] <= wdata at edge N. wr_cnt increments, holding at 2**CNT_W-1.
- Read (en=1, wr=0 at edge N): rdata <= mem[addr] at edge N. rvalid = 1 for the cycle after N. rd_cnt increments with saturation.
- Idle (en=0): no array or counter change, rvalid = 0, rdata holds its last value.
- Read-after-write to the same address in consecutive cycles returns the newly written data. The write completes at edge N and the read samples at edge N+1.
- Sequence FSM, evaluated only on accepted edges:
  - IDLE: en=1 -> FIRST.
  - FIRST or STREAM:
    - en=0 -> IDLE.
    - en=1, addr == last_addr+1 mod 2**ADDR_W and wr == last_wr -> STREAM.
    - Any other en=1 -> FIRST.
  - On every en=1 edge, last_addr <= addr and last_wr <= wr.
  - in_stream = (state == STREAM), registered.
- Address wrap: 63 followed by 0 counts as sequential.
- A direction change (write then read) breaks the stream even when the addresses are consecutive.
- Reset asserted mid-access: the access is dropped and all state returns to reset values immediately. The first edge after rst_n deasserts is treated as an access from IDLE.

## Timing
- Inputs are sampled on the rising clk edge. The initiator changes them at or after the edge, so they must be stable before the next edge.
- Write latency: the array updates at the sampling edge.
- Read latency: 1 cycle. rdata and rvalid are registered and valid from edge N until edge N+1.
- Counters and in_stream update at the sampling edge and are visible in the following cycle.
- There is no back-pressure. Every en=1 cycle is accepted.

## Structure
- Shared package addr_bus_pkg holds:
  - ADDR_W, DATA_W, CNT_W defaults
  - typedef enum logic [1:0] {IDLE, FIRST, STREAM} seq_state_t
  - typedefs addr_t and data_t
- One sub-module, addr_seq_tracker, contains the FSM, last_addr/last_wr, and in_stream. The array and counters stay in the top.

## Test plan
- Reset check: pulse rst_n low mid-cycle -> all outputs 0 asynchronously; a read of addr 5 after release returns 0 with rvalid high for 1 cycle.
- Bus sequence:
  - Stimulus: en=1 at one edge and held through the writes and the first two reads, then dropped for the last:
    - write 12 (wdata 0xA5), write 14 (0x3C) — two consecutive accepted edges
    - read 23, read 48 — the next two edges
    - addr=56 presented with en=0
  - Required response:
    - wr_cnt = 2, rd_cnt = 2
    - reads return 0x00
    - no access at 56
    - in_stream never high
- Sequential run with wrap: write addrs 62, 63, 0, 1 with en held high -> in_stream rises in the cycle after addr 63 is sampled and stays high through addr 1; it drops one cycle after en falls.
- Read-after-write: write 0x77 to addr 9, then read addr 9 the next edge -> rdata = 0x77, rvalid = 1 one cycle after the read edge.
- Direction break: write 20, then read 21 -> in_stream stays 0; rd_cnt = 1, wr_cnt = 1.
- Saturation: 300 consecutive writes (CNT_W=8) -> wr_cnt holds 255 with no wrap; rd_cnt stays 0.
